// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace buffer: record layout and kind encoding.
// Optional build macro COMMIT_TRACE_NOP_EN is consumed by commit_trace_buffer.
package commit_trace_pkg;

  localparam int INUM_W = 32;
  localparam int PC_W   = 16;
  localparam int DATA_W = 16;
  localparam int REG_W  = 3;
  localparam int INST_W = 16;

  typedef enum logic [1:0] {
    KIND_REG  = 2'd0,
    KIND_MEM  = 2'd1,
    KIND_HALT = 2'd2,
    KIND_NOP  = 2'd3
  } kind_t;

  typedef struct packed {
    logic [INUM_W-1:0] inum;
    kind_t             kind;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              regwrite;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] wdata;
    logic              memread;
    logic              memwrite;
    logic [PC_W-1:0]   maddr;
    logic [DATA_W-1:0] mdata;
  } rec_t;

  // A store that also writes a register is still a REG record.
  function automatic kind_t rec_kind(
    input logic regwrite,
    input logic memwrite,
    input logic halt
  );
    kind_t k;
    k = KIND_NOP;
    if (regwrite)      k = KIND_REG;
    else if (memwrite) k = KIND_MEM;
    else if (halt)     k = KIND_HALT;
    return k;
  endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Retire-side inputs, reader handshake and status of the commit trace buffer.
// slave = the buffer, master = the core/reader side.
interface commit_trace_buffer_if;
  import commit_trace_pkg::*;

  logic              rt_valid;
  logic [PC_W-1:0]   rt_pc;
  logic [INST_W-1:0] rt_inst;
  logic              rt_regwrite;
  logic [REG_W-1:0]  rt_wreg;
  logic [DATA_W-1:0] rt_wdata;
  logic              rt_memread;
  logic              rt_memwrite;
  logic [PC_W-1:0]   rt_maddr;
  logic [DATA_W-1:0] rt_mdata;
  logic              rt_halt;
  logic              rd_ready;
  logic              rd_valid;
  rec_t              rd_rec;
  logic              trace_full;
  logic              overflow;
  logic              halted;
  logic              drained;
  logic [31:0]       inst_count;
  logic [31:0]       cycle_count;

  modport slave (
    input  rt_valid, rt_pc, rt_inst, rt_regwrite, rt_wreg,
    input  rt_wdata, rt_memread, rt_memwrite, rt_maddr,
    input  rt_mdata, rt_halt, rd_ready,
    output rd_valid, rd_rec, trace_full, overflow,
    output halted, drained, inst_count, cycle_count
  );

  modport master (
    output rt_valid, rt_pc, rt_inst, rt_regwrite, rt_wreg,
    output rt_wdata, rt_memread, rt_memwrite, rt_maddr,
    output rt_mdata, rt_halt, rd_ready,
    input  rd_valid, rd_rec, trace_full, overflow,
    input  halted, drained, inst_count, cycle_count
  );

endinterface

// File: rtl/trace_fifo.sv
// DEPTH-entry FIFO of records; head is read straight from registered storage.
// A push while full is dropped unless a pop frees the slot in the same cycle.
module trace_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         din,
  output logic                     full,
  input  logic                     pop,
  output T                         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  T             mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = cnt == (AW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      cnt <= cnt + 1'b1;
      else if (do_pop && !do_push) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retire-event recorder beside WB: numbers retirements, counts cycles, queues records.
// Define COMMIT_TRACE_NOP_EN to also record retirements with no side effect.
module commit_trace_buffer
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  commit_trace_buffer_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              retire;
  logic              capture;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;
  logic              halted_q;
  logic              overflow_q;
  logic [INUM_W-1:0] inst_q;
  logic [INUM_W-1:0] cycle_q;
  rec_t              rec;

  assign retire = bus.rt_valid && !halted_q;

`ifdef COMMIT_TRACE_NOP_EN
  assign capture = retire;
`else
  assign capture = retire &&
    (bus.rt_regwrite || bus.rt_memwrite || bus.rt_halt);
`endif

  always_comb begin
    rec          = '0;
    rec.inum     = inst_q;
    rec.kind     = rec_kind(bus.rt_regwrite, bus.rt_memwrite,
                            bus.rt_halt);
    rec.pc       = bus.rt_pc;
    rec.inst     = bus.rt_inst;
    rec.regwrite = bus.rt_regwrite;
    rec.wreg     = bus.rt_wreg;
    rec.wdata    = bus.rt_wdata;
    rec.memread  = bus.rt_memread;
    rec.memwrite = bus.rt_memwrite;
    rec.maddr    = bus.rt_maddr;
    rec.mdata    = bus.rt_mdata;
  end

  assign pop = !empty && bus.rd_ready;

  trace_fifo #(
    .DEPTH (DEPTH),
    .T     (rec_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .din   (rec),
    .full  (full),
    .pop   (pop),
    .dout  (bus.rd_rec),
    .empty (empty),
    .count (count)
  );

  // A halt that arrives while full is dropped but still freezes capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q   <= 1'b0;
      overflow_q <= 1'b0;
      inst_q     <= '0;
      cycle_q    <= '0;
    end else begin
      if (!halted_q)            cycle_q    <= cycle_q + 1'b1;
      if (retire)               inst_q     <= inst_q + 1'b1;
      if (retire && bus.rt_halt) halted_q  <= 1'b1;
      if (capture && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign bus.rd_valid    = !empty;
  assign bus.trace_full  = full;
  assign bus.overflow    = overflow_q;
  assign bus.halted      = halted_q;
  assign bus.drained     = halted_q && (count == '0);
  assign bus.inst_count  = inst_q;
  assign bus.cycle_count = cycle_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: queue-based reference model, directed scenarios, random traffic.
// Honours COMMIT_TRACE_NOP_EN in the reference model.
module tb_commit_trace_buffer;
  import commit_trace_pkg::*;

  localparam int DEPTH = 4;
`ifdef COMMIT_TRACE_NOP_EN
  localparam bit NOP_EN = 1'b1;
`else
  localparam bit NOP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  commit_trace_buffer_if bus();

  commit_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  rec_t        q[$];
  rec_t        log_q[$];
  logic [31:0] m_inst;
  logic [31:0] m_cyc;
  bit          m_ovf;
  bit          m_halt;
  bit          armed = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic kind_t exp_kind(input logic rw, input logic mw,
                                     input logic h);
    if (rw) return KIND_REG;
    if (mw) return KIND_MEM;
    if (h)  return KIND_HALT;
    return KIND_NOP;
  endfunction

  function automatic rec_t mk_rec(input logic [31:0] n);
    rec_t r;
    r.inum     = n;
    r.kind     = exp_kind(bus.rt_regwrite, bus.rt_memwrite, bus.rt_halt);
    r.pc       = bus.rt_pc;
    r.inst     = bus.rt_inst;
    r.regwrite = bus.rt_regwrite;
    r.wreg     = bus.rt_wreg;
    r.wdata    = bus.rt_wdata;
    r.memread  = bus.rt_memread;
    r.memwrite = bus.rt_memwrite;
    r.maddr    = bus.rt_maddr;
    r.mdata    = bus.rt_mdata;
    return r;
  endfunction

  function automatic rec_t log_at(input int i);
    rec_t r;
    r = '1;
    if (i < log_q.size()) r = log_q[i];
    return r;
  endfunction

  // Reference model: one queue of expected records, popped ones go to log_q.
  always @(posedge clk) begin : model
    bit pop, full0, ret, want;
    if (rst) begin
      q.delete();
      m_inst = '0;
      m_cyc  = '0;
      m_ovf  = 1'b0;
      m_halt = 1'b0;
      armed  = 1'b1;
    end else if (armed) begin
      full0 = q.size() == DEPTH;
      pop   = q.size() != 0 && bus.rd_ready;
      ret   = bus.rt_valid && !m_halt;
      want  = ret && (bus.rt_regwrite || bus.rt_memwrite ||
                      bus.rt_halt || NOP_EN);
      if (pop) log_q.push_back(q.pop_front());
      if (want) begin
        if (!full0 || pop) q.push_back(mk_rec(m_inst));
        else m_ovf = 1'b1;
      end
      if (!m_halt) m_cyc = m_cyc + 1;
      if (ret) begin
        m_inst = m_inst + 1;
        if (bus.rt_halt) m_halt = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (armed) begin
      chk("rd_valid", 128'(bus.rd_valid), 128'(q.size() != 0));
      if (q.size() != 0)
        chk("rd_rec", 128'(bus.rd_rec), 128'(q[0]));
      chk("trace_full", 128'(bus.trace_full), 128'(q.size() == DEPTH));
      chk("overflow", 128'(bus.overflow), 128'(m_ovf));
      chk("halted", 128'(bus.halted), 128'(m_halt));
      chk("drained", 128'(bus.drained), 128'(m_halt && q.size() == 0));
      chk("inst_count", 128'(bus.inst_count), 128'(m_inst));
      chk("cycle_count", 128'(bus.cycle_count), 128'(m_cyc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.rt_valid    = 1'b0;
    bus.rt_pc       = '0;
    bus.rt_inst     = '0;
    bus.rt_regwrite = 1'b0;
    bus.rt_wreg     = '0;
    bus.rt_wdata    = '0;
    bus.rt_memread  = 1'b0;
    bus.rt_memwrite = 1'b0;
    bus.rt_maddr    = '0;
    bus.rt_mdata    = '0;
    bus.rt_halt     = 1'b0;
  endtask

  task automatic retire(input logic [15:0] pc, input logic [15:0] inst,
                        input logic rw, input logic [2:0] wreg,
                        input logic [15:0] wdata, input logic mw,
                        input logic [15:0] maddr, input logic [15:0] mdata,
                        input logic h);
    bus.rt_valid    = 1'b1;
    bus.rt_pc       = pc;
    bus.rt_inst     = inst;
    bus.rt_regwrite = rw;
    bus.rt_wreg     = wreg;
    bus.rt_wdata    = wdata;
    bus.rt_memread  = 1'b0;
    bus.rt_memwrite = mw;
    bus.rt_maddr    = maddr;
    bus.rt_mdata    = mdata;
    bus.rt_halt     = h;
  endtask

  task automatic reg_wr(input int i);
    retire(16'(2 * i), 16'h1000 + 16'(i), 1'b1, 3'(i), 16'(i + 100),
           1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    log_q.delete();
  endtask

  initial begin : stim
    int pct;
    idle();
    bus.rd_ready = 1'b0;
    repeat (2) step();

    // 1: addi, store, halt
    do_reset();
    bus.rd_ready = 1'b1;
    retire(16'h0000, 16'h5245, 1'b1, 3'd1, 16'd5, 1'b0, '0, '0, 1'b0);
    step();
    retire(16'h0002, 16'h7410, 1'b0, 3'd0, '0, 1'b1, 16'h0010, 16'd7,
           1'b0);
    step();
    retire(16'h0004, 16'hF000, 1'b0, 3'd0, '0, 1'b0, '0, '0, 1'b1);
    step();
    idle();
    repeat (3) step();
    chk("s1_nrec", 128'(log_q.size()), 128'd3);
    for (int i = 0; i < 3; i++) begin
      chk("s1_inum", 128'(log_at(i).inum), 128'(i));
      chk("s1_kind", 128'(log_at(i).kind), 128'(i));
    end
    chk("s1_wdata", 128'(log_at(0).wdata), 128'd5);
    chk("s1_maddr", 128'(log_at(1).maddr), 128'h10);
    chk("s1_halted", 128'(bus.halted), 128'd1);
    chk("s1_drained", 128'(bus.drained), 128'd1);
    chk("s1_icount", 128'(bus.inst_count), 128'd3);

    // 2: fill, overflow, drain
    do_reset();
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      reg_wr(i);
      step();
      if (i == 2) chk("s2_notfull", 128'(bus.trace_full), 128'd0);
      if (i == 3) chk("s2_full", 128'(bus.trace_full), 128'd1);
    end
    idle();
    step();
    chk("s2_ovf", 128'(bus.overflow), 128'd1);
    chk("s2_icount", 128'(bus.inst_count), 128'd6);
    bus.rd_ready = 1'b1;
    repeat (6) step();
    chk("s2_nrec", 128'(log_q.size()), 128'd4);
    for (int i = 0; i < 4; i++)
      chk("s2_inum", 128'(log_at(i).inum), 128'(i));

    // 3: push and pop while full
    do_reset();
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      reg_wr(i);
      step();
    end
    reg_wr(4);
    bus.rd_ready = 1'b1;
    step();
    bus.rd_ready = 1'b0;
    idle();
    step();
    chk("s3_full", 128'(bus.trace_full), 128'd1);
    chk("s3_ovf", 128'(bus.overflow), 128'd0);
    chk("s3_pop0", 128'(log_at(0).inum), 128'd0);
    bus.rd_ready = 1'b1;
    repeat (5) step();
    chk("s3_nrec", 128'(log_q.size()), 128'd5);
    chk("s3_tail", 128'(log_at(4).inum), 128'd4);

    // 4: branch then reg write
    do_reset();
    bus.rd_ready = 1'b1;
    retire(16'h0020, 16'hC004, 1'b0, 3'd0, '0, 1'b0, '0, '0, 1'b0);
    step();
    reg_wr(2);
    step();
    idle();
    repeat (3) step();
`ifdef COMMIT_TRACE_NOP_EN
    chk("s4_nrec", 128'(log_q.size()), 128'd2);
    chk("s4_inum0", 128'(log_at(0).inum), 128'd0);
    chk("s4_kind0", 128'(log_at(0).kind), 128'(KIND_NOP));
    chk("s4_inum1", 128'(log_at(1).inum), 128'd1);
    chk("s4_kind1", 128'(log_at(1).kind), 128'(KIND_REG));
`else
    chk("s4_nrec", 128'(log_q.size()), 128'd1);
    chk("s4_inum", 128'(log_at(0).inum), 128'd1);
    chk("s4_kind", 128'(log_at(0).kind), 128'(KIND_REG));
`endif

    // 5: bubbles with junk fields
    do_reset();
    bus.rd_ready = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      if (c == 2 || c == 5) begin
        reg_wr(c);
      end else begin
        retire(16'($urandom), 16'($urandom), 1'b1, 3'd7, 16'($urandom),
               1'b1, 16'($urandom), 16'($urandom), 1'b1);
        bus.rt_valid = 1'b0;
      end
      step();
    end
    idle();
    chk("s5_icount", 128'(bus.inst_count), 128'd2);
    chk("s5_ccount", 128'(bus.cycle_count), 128'd10);
    chk("s5_nrec", 128'(log_q.size()), 128'd2);

    // 6: reset with records queued, overflow and halt set
    do_reset();
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      reg_wr(i);
      step();
    end
    retire(16'h0040, 16'hF000, 1'b0, 3'd0, '0, 1'b0, '0, '0, 1'b1);
    step();
    idle();
    step();
    chk("s6_pre_ovf", 128'(bus.overflow), 128'd1);
    chk("s6_pre_halt", 128'(bus.halted), 128'd1);
    rst = 1'b1;
    step();
    chk("s6_valid", 128'(bus.rd_valid), 128'd0);
    chk("s6_icount", 128'(bus.inst_count), 128'd0);
    chk("s6_ccount", 128'(bus.cycle_count), 128'd0);
    chk("s6_ovf", 128'(bus.overflow), 128'd0);
    chk("s6_halt", 128'(bus.halted), 128'd0);
    rst = 1'b0;

    // random traffic against the model
    do_reset();
    pct = 50;
    for (int n = 0; n < 4000; n++) begin
      int r;
      if (n % 200 == 0) pct = (n / 200) % 3 == 0 ? 90 :
                              (n / 200) % 3 == 1 ? 15 : 50;
      r = int'($urandom_range(0, 9));
      retire(16'($urandom), 16'($urandom), 1'b0, 3'($urandom),
             16'($urandom), 1'b0, 16'($urandom), 16'($urandom), 1'b0);
      bus.rt_valid   = $urandom_range(0, 3) != 0;
      bus.rt_memread = 1'b0;
      case (r)
        0, 1, 2, 3: bus.rt_regwrite = 1'b1;
        4, 5:       bus.rt_memwrite = 1'b1;
        6: begin
          bus.rt_regwrite = 1'b1;
          bus.rt_memwrite = 1'b1;
        end
        7:       bus.rt_memread = 1'b1;
        8:       ;
        default: begin
          if ($urandom_range(0, 9) == 0) bus.rt_halt = 1'b1;
          else bus.rt_regwrite = 1'b1;
        end
      endcase
      bus.rd_ready = int'($urandom_range(0, 99)) < pct;
      rst = ($urandom_range(0, 499) == 0) ||
            (m_halt && $urandom_range(0, 15) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    bus.rd_ready = 1'b1;
    repeat (DEPTH + 2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
